// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon data feeder.
package ascon_pack;

  localparam int unsigned BLK_W = 64;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AD    = 2'd1,
    PT    = 2'd2,
    DRAIN = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/block_fifo.sv
// Two-entry block FIFO; a push on a full FIFO is taken when a pop happens in the same cycle.
module block_fifo #(
  parameter int unsigned W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign w_push = push_i & (~full_o | pop_i);
  assign w_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= din_i;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end

  assign dout_o  = r_mem[r_rp];
  assign full_o  = (r_cnt == 2'd2);
  assign empty_o = (r_cnt == 2'd0);

endmodule

// File: rtl/ascon_data_feeder.sv
// Packs an AD+PT byte stream into padded 64-bit Ascon blocks and serves them to the core on request.
module ascon_data_feeder
  import ascon_pack::*;
#(
  parameter int unsigned BLK_AW = 10,
  parameter int unsigned LEN_W  = BLK_AW + 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_valid_i,
  input  logic [LEN_W-1:0]  ad_len_i,
  input  logic [LEN_W-1:0]  pt_len_i,
  output logic              cfg_ready_o,
  output logic              cfg_err_o,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  input  logic              blk_req_i,
  output logic [BLK_W-1:0]  blk_o,
  output logic              blk_valid_o,
  output logic [BLK_AW-1:0] ad_size_o,
  output logic [BLK_AW-1:0] pt_size_o,
  output logic              done_o
);

  feeder_state_t     r_state, w_state_nxt;
  logic [BLK_W-1:0]  r_pack;
  logic [2:0]        r_idx;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_full;
  logic              r_fin;
  logic [LEN_W-1:0]  r_ad_len;
  logic [LEN_W-1:0]  r_pt_len;
  logic [BLK_AW-1:0] r_ad_size;
  logic [BLK_AW-1:0] r_pt_size;
  logic              r_pend;
  logic [BLK_W-1:0]  r_blk;
  logic              r_blk_valid;
  logic              r_done;
  logic              r_cfg_err;

  logic              w_in_sec;
  logic [LEN_W-1:0]  w_len;
  logic              w_fire;
  logic              w_last_byte;
  logic              w_cmpl;
  logic              w_fin_merge;
  logic              w_pad_only;
  logic [2:0]        w_idx_nxt;
  logic [5:0]        w_shift;
  logic [5:0]        w_pad_shift;
  logic [BLK_W-1:0]  w_merge;
  logic              w_len_bad;
  logic              w_pend;
  logic              w_pop;
  logic              w_can_push;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [BLK_W-1:0]  w_fifo_dout;
  logic              w_push;
  logic [BLK_W-1:0]  w_push_data;
  logic              w_sec_end;
  logic              w_hold;
  logic              w_done;
  logic              w_cfg_ok;
  logic              w_cfg_err;

  assign w_in_sec     = (r_state == AD) || (r_state == PT);
  assign w_len        = (r_state == PT) ? r_pt_len : r_ad_len;
  assign byte_ready_o = w_in_sec && !r_full && (r_cnt != w_len);
  assign cfg_ready_o  = (r_state == IDLE);
  assign w_fire       = byte_valid_i && byte_ready_o;

  // Merge the incoming byte big-endian; the section's last byte also gets the pad marker behind it.
  assign w_last_byte  = ((r_cnt + LEN_W'(1)) == w_len);
  assign w_idx_nxt    = r_idx + 3'd1;
  assign w_shift      = {r_idx, 3'b000};
  assign w_pad_shift  = {w_idx_nxt, 3'b000};
  assign w_fin_merge  = w_last_byte && (r_idx != 3'd7);
  assign w_merge      = r_pack | ({byte_i, 56'd0} >> w_shift)
                      | (w_fin_merge ? ({PAD_BYTE, 56'd0} >> w_pad_shift) : '0);
  assign w_cmpl       = w_fire && ((r_idx == 3'd7) || w_last_byte);
  assign w_pad_only   = w_in_sec && !r_full && (r_cnt == w_len) && (r_idx == 3'd0)
                      && (w_len[2:0] == 3'd0);

  assign w_len_bad    = (ad_len_i[LEN_W-1:3] == '1) || (pt_len_i[LEN_W-1:3] == '1);

  // At most one outstanding request; a request arriving this cycle can pop immediately.
  assign w_pend       = r_pend || (blk_req_i && (r_state != IDLE));
  assign w_pop        = w_pend && !w_fifo_empty;
  assign w_can_push   = !w_fifo_full || w_pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_data = r_pack;
    w_sec_end   = 1'b0;
    w_hold      = 1'b0;
    w_done      = 1'b0;
    w_cfg_ok    = 1'b0;
    w_cfg_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg_valid_i) begin
          if (w_len_bad) begin
            w_cfg_err = 1'b1;
          end else begin
            w_cfg_ok    = 1'b1;
            w_state_nxt = AD;
          end
        end
      end
      AD, PT: begin
        if (r_full) begin
          w_push    = w_can_push;
          w_sec_end = w_can_push && r_fin;
        end else if (w_cmpl) begin
          w_push      = w_can_push;
          w_push_data = w_merge;
          w_hold      = !w_can_push;
          w_sec_end   = w_can_push && w_fin_merge;
        end else if (w_pad_only) begin
          w_push      = w_can_push;
          w_push_data = {PAD_BYTE, 56'd0};
          w_sec_end   = w_can_push;
        end
        if (w_sec_end) w_state_nxt = (r_state == AD) ? PT : DRAIN;
      end
      DRAIN: begin
        if (w_pop && !w_fifo_full) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pack      <= '0;
      r_idx       <= 3'd0;
      r_cnt       <= '0;
      r_full      <= 1'b0;
      r_fin       <= 1'b0;
      r_ad_len    <= '0;
      r_pt_len    <= '0;
      r_ad_size   <= '0;
      r_pt_size   <= '0;
      r_pend      <= 1'b0;
      r_blk       <= '0;
      r_blk_valid <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err   <= w_cfg_err;
      r_done      <= w_done;
      r_blk_valid <= w_pop;
      r_pend      <= w_pend && !w_pop;
      if (w_pop) r_blk <= w_fifo_dout;
      if (w_cfg_ok) begin
        r_ad_len  <= ad_len_i;
        r_pt_len  <= pt_len_i;
        r_ad_size <= BLK_AW'(ad_len_i >> 3) + BLK_AW'(1);
        r_pt_size <= BLK_AW'(pt_len_i >> 3) + BLK_AW'(1);
      end
      // Packer restarts at every section boundary.
      if (w_cfg_ok || w_sec_end) begin
        r_pack <= '0;
        r_idx  <= 3'd0;
        r_cnt  <= '0;
        r_full <= 1'b0;
        r_fin  <= 1'b0;
      end else begin
        if (w_fire) begin
          r_cnt  <= r_cnt + LEN_W'(1);
          r_idx  <= w_cmpl ? 3'd0 : w_idx_nxt;
          r_pack <= (w_cmpl && !w_hold) ? '0 : w_merge;
        end
        if (w_hold) begin
          r_full <= 1'b1;
          r_fin  <= w_fin_merge;
        end
        if (r_full && w_push) begin
          r_pack <= '0;
          r_full <= 1'b0;
          r_fin  <= 1'b0;
        end
      end
    end
  end

  block_fifo #(.W(BLK_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .din_i   (w_push_data),
    .pop_i   (w_pop),
    .dout_o  (w_fifo_dout),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  assign blk_o       = r_blk;
  assign blk_valid_o = r_blk_valid;
  assign ad_size_o   = r_ad_size;
  assign pt_size_o   = r_pt_size;
  assign done_o      = r_done;
  assign cfg_err_o   = r_cfg_err;

endmodule
